// File: rtl/bb_scrambler_pkg.sv
// bb_scrambler_pkg: shared constants and FSM state type for the BB scrambler frame sequencer.
package bb_scrambler_pkg;
    localparam int FRAME_BITS = 1504;
    localparam int PRBS_W = 15;
    localparam logic [PRBS_W-1:0] PRBS_INIT = 15'b100101010000000;
    localparam int GAP_CYCLES = 2;
    localparam int LATENCY = 1;
    localparam int BIT_W = 11;
    localparam int WAIT_W = 2;
    typedef enum logic [2:0] {IDLE, LOAD, GAP, RUN, DRAIN} ctrl_state_t;
endpackage

// File: rtl/bb_scrambler_ctrl_if.sv
// bb_scrambler_ctrl_if: control/data bus between the frame sequencer and the BB_scrambler instance.
interface bb_scrambler_ctrl_if;
    import bb_scrambler_pkg::*;
    logic rst_n;
    logic en;
    logic in_bit;
    logic out_bit;
    logic [PRBS_W-1:0] init_state;
    modport master(output rst_n, init_state, en, in_bit, input out_bit);
    modport slave(input rst_n, init_state, en, in_bit, output out_bit);
endinterface

// File: rtl/bb_valid_delay.sv
// bb_valid_delay: LATENCY-deep shift register of {valid, sof, eof}, advancing only when the scrambler is enabled.
module bb_valid_delay #(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [2:0] d,
    output logic [2:0] q
);
    logic [2:0] sr [LATENCY];
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clr) begin
            for (int i = 0; i < LATENCY; i++) sr[i] <= '0;
        end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < LATENCY; i++) sr[i] <= sr[i-1];
        end
    end
    assign q = sr[LATENCY-1];
endmodule

// File: rtl/bb_scrambler_ctrl.sv
// bb_scrambler_ctrl: cuts a serial bit stream into BB frames, reloads the scrambler PRBS per frame
// and re-aligns the scrambled bits with frame markers.
module bb_scrambler_ctrl
    import bb_scrambler_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                abort,
    input  logic                in_bit,
    input  logic                in_valid,
    output logic                in_ready,
    bb_scrambler_ctrl_if.master scmb,
    output logic                out_bit,
    output logic                out_valid,
    output logic                out_sof,
    output logic                out_eof,
    output logic [15:0]         frame_cnt,
    output logic                abort_err
);
    ctrl_state_t       state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              accept;
    logic              last;
    logic              take_abort;
    logic              adv;
    logic              emit;
    logic [2:0]        tail;

    assign in_ready        = state == RUN;
    assign accept          = in_ready & in_valid;
    assign last            = accept & (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign take_abort      = abort & (state inside {GAP, RUN, DRAIN});
    assign scmb.rst_n      = state inside {GAP, RUN, DRAIN};
    assign scmb.init_state = PRBS_INIT;
    assign scmb.en         = accept | (state == DRAIN);
    assign scmb.in_bit     = in_ready & in_bit;

    bb_valid_delay #(.LATENCY(LATENCY)) u_dly (
        .clk  (clk),
        .reset(reset),
        .clr  (take_abort),
        .en   (scmb.en),
        .d    ({accept, bit_cnt == '0, last}),
        .q    (tail)
    );

    // The scrambled bit is only stable the cycle after an enabled edge, so flags are
    // emitted once per advance; an abort discards whatever is still in flight.
    assign emit = adv & tail[2] & ~take_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adv       <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            adv       <= scmb.en & ~take_abort;
            out_valid <= emit;
            out_sof   <= emit & tail[1];
            out_eof   <= emit & tail[0];
            out_bit   <= emit & scmb.out_bit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            frame_cnt <= '0;
            abort_err <= 1'b0;
        end else begin
            abort_err <= take_abort & ((state == DRAIN) | (bit_cnt != '0) | accept);
            if (take_abort) begin
                state    <= LOAD;
                bit_cnt  <= '0;
                wait_cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (in_valid) state <= LOAD;
                    LOAD: begin
                        state    <= GAP;
                        wait_cnt <= '0;
                    end
                    GAP: begin
                        state    <= (wait_cnt == WAIT_W'(GAP_CYCLES - 1)) ? RUN : GAP;
                        wait_cnt <= (wait_cnt == WAIT_W'(GAP_CYCLES - 1)) ? '0 : wait_cnt + 1'b1;
                    end
                    RUN: begin
                        state   <= last ? DRAIN : RUN;
                        bit_cnt <= last ? '0 : bit_cnt + BIT_W'(accept);
                    end
                    DRAIN: begin
                        if (wait_cnt == WAIT_W'(LATENCY - 1)) begin
                            state     <= in_valid ? LOAD : IDLE;
                            wait_cnt  <= '0;
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bb_scrambler_ctrl.sv
// tb_bb_scrambler_ctrl: frame sequencer driven with a behavioural BB_scrambler; outputs checked
// against input bits XOR a PRBS sequence computed from the x^15+x^14+1 recurrence.
module tb_bb_scrambler_ctrl;
    import bb_scrambler_pkg::*;
    localparam int FB = FRAME_BITS;

    logic        clk = 1'b0;
    logic        reset, abort, in_bit, in_valid, in_ready;
    logic        out_bit, out_valid, out_sof, out_eof, abort_err;
    logic [15:0] frame_cnt;

    bb_scrambler_ctrl_if scmb();

    bb_scrambler_ctrl dut (
        .clk(clk), .reset(reset), .abort(abort), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .scmb(scmb), .out_bit(out_bit), .out_valid(out_valid),
        .out_sof(out_sof), .out_eof(out_eof), .frame_cnt(frame_cnt), .abort_err(abort_err)
    );

    always #5 clk = ~clk;

    // Behavioural BB_scrambler: synchronous reload, one enabled cycle of latency.
    logic [PRBS_W-1:0] st;
    always @(posedge clk) begin
        if (!scmb.rst_n) begin
            st           <= scmb.init_state;
            scmb.out_bit <= 1'b0;
        end else if (scmb.en) begin
            st           <= {st[1] ^ st[0], st[PRBS_W-1:1]};
            scmb.out_bit <= scmb.in_bit ^ st[1] ^ st[0];
        end
    end

    int vectors = 0, errors = 0;
    int nacc = 0, k = 0, frames_seen = 0, total_acc = 0;
    bit mon_en = 1'b0;
    bit prbs [FB];
    bit fin [FB];

    typedef struct packed {
        logic vin, bin, rst_n, en, rdy, ov, ob, sof;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset && out_valid) begin
            chk($sformatf("frame_bit%0d {bit,sof,eof}", k), int'({out_bit, out_sof, out_eof}),
                int'({fin[k] ^ prbs[k], k == 0, k == FB - 1}));
            if (k == FB - 1) begin
                k = 0;
                frames_seen++;
            end else begin
                k++;
            end
        end
    end

    task automatic cyc(input bit v, input bit b, input bit ab);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        abort    = ab;
        if (v && in_ready && !ab) begin
            fin[nacc] = b;
            nacc = (nacc == FB - 1) ? 0 : nacc + 1;
            total_acc++;
        end
    endtask

    task automatic run_bits(input int n, input int mode);
        int start = total_acc;
        int budget = 0;
        bit tog = 1'b1;
        bit v;
        while (total_acc - start < n && budget < 8 * FB) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(3) != 0);
            cyc(v, 1'($urandom), 1'b0);
            tog = !tog;
            budget++;
        end
        if (total_acc - start < n) begin
            errors++;
            $display("FAIL run_bits timeout: accepted %0d, required %0d", total_acc - start, n);
        end
    endtask

    task automatic do_abort(input bit v, input bit b, input int exp_err, input string nm);
        cyc(v, b, 1'b1);
        @(posedge clk);
        #1;
        chk(nm, int'(abort_err), exp_err);
        nacc = 0;
        k = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int y [FB + PRBS_W];
        logic [PRBS_W-1:0] seed;
        seed = PRBS_INIT;
        for (int i = 0; i < PRBS_W; i++) y[i] = int'(seed[i]);
        for (int n = 0; n < FB; n++) begin
            y[n + PRBS_W] = y[n + 1] ^ y[n];
            prbs[n] = y[n + PRBS_W][0];
        end

        //            vin bin rst_n en rdy ov ob sof
        tbl[0]  = 8'b0_0_0_0_0_0_0_0;
        tbl[1]  = 8'b1_0_0_0_0_0_0_0;
        tbl[2]  = 8'b1_0_0_0_0_0_0_0;
        tbl[3]  = 8'b1_0_1_0_0_0_0_0;
        tbl[4]  = 8'b1_0_1_0_0_0_0_0;
        tbl[5]  = 8'b1_1_1_1_1_0_0_0;
        tbl[6]  = 8'b0_0_1_0_1_0_0_0;
        tbl[7]  = 8'b0_0_1_0_1_1_1_1;
        tbl[8]  = 8'b1_1_1_1_1_0_0_0;
        tbl[9]  = 8'b0_0_1_0_1_0_0_0;
        tbl[10] = 8'b0_0_1_0_1_1_1_0;

        reset = 1'b1; abort = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", int'({in_ready, scmb.rst_n, scmb.en, scmb.in_bit, out_valid,
            out_sof, out_eof, out_bit, abort_err}), 0);
        chk("reset_frame_cnt", int'(frame_cnt), 0);
        chk("init_state", int'(scmb.init_state), int'(15'b100101010000000));
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid = tbl[i].vin;
            in_bit   = tbl[i].bin;
            #1;
            chk($sformatf("tbl%0d {rst_n,en,rdy,ov,ob,sof}", i),
                int'({scmb.rst_n, scmb.en, in_ready, out_valid, out_bit, out_sof}),
                int'({tbl[i].rst_n, tbl[i].en, tbl[i].rdy, tbl[i].ov, tbl[i].ob, tbl[i].sof}));
        end

        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;

        run_bits(FB, 1);
        run_bits(FB, 0);
        run_bits(FB, 0);
        repeat (8) cyc(1'b0, 1'b0, 1'b0);
        chk("frame_cnt_after_3", int'(frame_cnt), 3);
        chk("frames_out_after_3", frames_seen, 3);

        run_bits(700, 2);
        do_abort(1'b1, 1'($urandom), 1, "abort_err_mid_frame");
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        chk("frame_cnt_after_abort", int'(frame_cnt), 3);
        run_bits(FB, 2);
        repeat (8) cyc(1'b0, 1'b0, 1'b0);
        chk("frame_cnt_after_restart", int'(frame_cnt), 4);
        chk("frames_out_after_restart", frames_seen, 4);

        run_bits(FB - 1, 0);
        do_abort(1'b1, 1'($urandom), 1, "abort_err_last_bit");
        cyc(1'b1, 1'b0, 1'b0);
        do_abort(1'b1, 1'b0, 0, "abort_err_in_gap");
        run_bits(FB, 0);
        repeat (8) cyc(1'b0, 1'b0, 1'b0);
        chk("frame_cnt_after_drop", int'(frame_cnt), 5);
        chk("frames_out_after_drop", frames_seen, 5);

        run_bits(300, 0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        #1;
        chk("midframe_reset_outputs", int'({in_ready, scmb.rst_n, scmb.en, scmb.in_bit, out_valid,
            out_sof, out_eof, out_bit, abort_err}), 0);
        chk("midframe_reset_frame_cnt", int'(frame_cnt), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        nacc = 0; k = 0; frames_seen = 0;
        run_bits(FB, 2);
        repeat (8) cyc(1'b0, 1'b0, 1'b0);
        chk("frame_cnt_after_reset", int'(frame_cnt), 1);
        chk("frames_out_after_reset", frames_seen, 1);

        do_abort(1'b0, 1'b0, 0, "abort_err_in_idle");
        cyc(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("idle_abort_ignored {rst_n,rdy}", int'({scmb.rst_n, in_ready}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
